// File: rtl/rotate_lane_engine.sv
// ----------------------------------------------------------------------------
// rotate_lane_engine
//
// Applies the Keccak rho lane rotations to a 5x5 page of lanes, a few lanes
// per clock. inv=0 rotates each lane left by its rho offset. inv=1 rotates it
// right by the same offset, which undoes a previous forward pass.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst       : synchronous, active-low reset
//   start     : request to process page_in (accepted only while idle)
//   inv       : 0 = rotate left (rho), 1 = rotate right (inverse rho)
//   page_in   : input page, lane (x,y) at bits [LANE_W*(5*y+x) +: LANE_W]
//   page_out  : registered result page, same lane layout as page_in
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse when a new page_out becomes valid
//
// Parameters
//   LANE_W          : lane width in bits (8, 16, 32 or 64)
//   LANES_PER_CYCLE : lanes rotated per cycle (1, 5 or 25)
// ----------------------------------------------------------------------------
module rotate_lane_engine #(
    parameter int LANE_W          = 64,
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   inv,
    input  logic [25*LANE_W-1:0]   page_in,
    output logic [25*LANE_W-1:0]   page_out,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Rho offsets indexed by 5*y+x. Each offset is reduced mod LANE_W at use.
    localparam int RHO [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    localparam logic [4:0] STEP = 5'(LANES_PER_CYCLE);
    // Counter value during the final ROT cycle.
    localparam logic [4:0] LAST = 5'(25 - LANES_PER_CYCLE);

    state_t                 state;
    state_t                 state_next;
    logic [4:0]             cnt;
    logic                   mode;
    logic [25*LANE_W-1:0]   work;
    logic [25*LANE_W-1:0]   work_rot;

    // Rotates through a doubled copy of the lane, so an offset of 0 returns
    // the lane unchanged in both directions.
    function automatic logic [LANE_W-1:0] rot_lane(
        input logic [LANE_W-1:0] v,
        input int                off,
        input logic              right
    );
        logic [2*LANE_W-1:0] dbl;
        dbl = {v, v};
        if (right) begin
            dbl = dbl >> off;
            return dbl[LANE_W-1:0];
        end
        dbl = dbl << off;
        return dbl[2*LANE_W-1:LANE_W];
    endfunction

    // The current group of lanes is rotated in place. All other lanes pass
    // through unchanged.
    always_comb begin
        // NOTE: a full default before any conditional write keeps this block
        // purely combinational; a path that skipped work_rot would infer a latch.
        work_rot = work;
        for (int i = 0; i < 25; i++) begin
            if (5'(i) >= cnt && 5'(i) < cnt + STEP) begin
                work_rot[LANE_W*i +: LANE_W] =
                    rot_lane(work[LANE_W*i +: LANE_W], RHO[i] % LANE_W, mode);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ROT;
            ROT:     if (cnt == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs before any of them update.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the work page is an ordinary register, not a RAM, so it is
            // cleared here together with the rest of the state.
            cnt      <= '0;
            mode     <= 1'b0;
            work     <= '0;
            page_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= page_in;
                        mode <= inv;
                        cnt  <= '0;
                    end
                end
                ROT: begin
                    work <= work_rot;
                    cnt  <= cnt + STEP;
                end
                FIN: begin
                    page_out <= work;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
